shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding a registered shift/rotate unit.
// One result register with valid/ready handshake; a grant is taken only when that register can accept.
module shift_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] a_data,
  input  logic [4:0]   a_shamt,
  input  logic [1:0]   a_ctrl,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [W-1:0] b_data,
  input  logic [4:0]   b_shamt,
  input  logic [1:0]   b_ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_src
);

  logic         out_valid_r;
  logic [W-1:0] out_data_r;
  logic         out_src_r;
  logic         prio_r;

  logic         can_accept_s;
  logic         any_req_s;
  logic         grant_b_s;
  logic         xfer_s;
  logic [W-1:0] sel_data_s;
  logic [4:0]   sel_shamt_s;
  logic [1:0]   sel_ctrl_s;
  logic [W-1:0] result_s;

  // Shift amounts of W or more drain every bit out, so the SV shift result of 0 is what we want.
  function automatic logic [W-1:0] shift_op(input logic [W-1:0] d,
                                            input logic [4:0]   sh,
                                            input logic [1:0]   op);
    logic [W-1:0] r;
    int           amt;
    r   = {W{1'b0}};
    amt = int'(sh) % W;
    case (op)
      2'b00: r = d << sh;
      2'b01: r = d >> sh;
      2'b10: begin
        r = d >> sh;
        if (d[W-1]) begin
          r = ~r + {{(W-1){1'b0}}, 1'b1};
        end else begin
          r = r;
        end
      end
      2'b11: r = (d >> amt) | (d << (W - amt));
      default: r = {W{1'b0}};
    endcase
    return r;
  endfunction

  assign can_accept_s = !out_valid_r || out_ready;
  assign any_req_s    = a_valid || b_valid;
  assign grant_b_s    = b_valid && (!a_valid || prio_r);
  assign xfer_s       = any_req_s && can_accept_s && !rst;
  assign a_ready      = xfer_s && !grant_b_s;
  assign b_ready      = xfer_s && grant_b_s;

  // Operand mux for the granted requester.
  always_comb begin
    sel_data_s  = a_data;
    sel_shamt_s = a_shamt;
    sel_ctrl_s  = a_ctrl;
    if (grant_b_s) begin
      sel_data_s  = b_data;
      sel_shamt_s = b_shamt;
      sel_ctrl_s  = b_ctrl;
    end else begin
      sel_data_s  = a_data;
      sel_shamt_s = a_shamt;
      sel_ctrl_s  = a_ctrl;
    end
  end

  assign result_s = shift_op(sel_data_s, sel_shamt_s, sel_ctrl_s);

  // Result register and round-robin pointer; a drain and a new load may share an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_src_r   <= 1'b0;
      prio_r      <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
      out_src_r   <= grant_b_s;
      prio_r      <= !grant_b_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

  shift_arbiter_chk #(.W(W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

endmodule

// Handshake invariants of shift_arbiter; simulation-only, ignored by synthesis.
module shift_arbiter_chk #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         rst,
  input logic         a_ready,
  input logic         b_ready,
  input logic         out_valid,
  input logic         out_ready,
  input logic [W-1:0] out_data,
  input logic         out_src
);

  a_one_grant: assert property (@(posedge clk) !(a_ready && b_ready));

  a_rst_no_grant: assert property (@(posedge clk) rst |-> (!a_ready && !b_ready));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_src)));

  a_stall_no_grant: assert property (@(posedge clk)
    (out_valid && !out_ready) |-> (!a_ready && !b_ready));

endmodule
